motor_mix_ctrl: RTL and testbench

Parametrised motor mixer and arming sequencer. It sits between the PID stage and the four `pwm` instances in the flight-control top level. It converts per-frame pitch, roll and yaw corrections plus a ramped collective throttle into four clamped duty values with `speed_oe`-style strobes. It also provides throttle-low arming, timed spin-up, throttle slew limiting, and a sensor-loss watchdog with controlled descent.

---
 rtl/motor_mix_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_motor_mix_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_mix_ctrl.sv
// Motor mixer and arming sequencer: ramped collective throttle, quad-X/plus mixing,
// throttle-low arming, timed spin-up and a sensor-loss watchdog with controlled descent.
module motor_mix_ctrl #(
    parameter int DUTY_W      = 16,
    parameter int CORR_W      = 24,
    parameter int CORR_SHIFT  = 8,
    parameter int MIX_MODE    = 0,
    parameter int PWM_MIN     = 0,
    parameter int PWM_IDLE    = 8000,
    parameter int PWM_MAX     = 60000,
    parameter int RAMP_STEP   = 200,
    parameter int RAMP_DIV    = 50000,
    parameter int SPIN_TICKS  = 500,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic [DUTY_W-1:0]        thr_target,
    input  logic                     corr_valid,
    input  logic signed [CORR_W-1:0] corr_pitch,
    input  logic signed [CORR_W-1:0] corr_roll,
    input  logic signed [CORR_W-1:0] corr_yaw,
    output logic [DUTY_W-1:0]        duty_1,
    output logic [DUTY_W-1:0]        duty_2,
    output logic [DUTY_W-1:0]        duty_3,
    output logic [DUTY_W-1:0]        duty_4,
    output logic                     duty_oe,
    output logic [1:0]               mix_state,
    output logic                     failsafe
);
    localparam int SW  = CORR_W + 2;
    localparam int TW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int WW  = $clog2(TIMEOUT_CYC + 1);
    localparam int STW = $clog2(SPIN_TICKS + 1);

    localparam logic [DUTY_W-1:0] P_MIN  = DUTY_W'(PWM_MIN);
    localparam logic [DUTY_W-1:0] P_IDLE = DUTY_W'(PWM_IDLE);
    localparam logic [DUTY_W-1:0] P_MAX  = DUTY_W'(PWM_MAX);
    localparam logic [DUTY_W-1:0] STEP   = DUTY_W'(RAMP_STEP);
    localparam logic signed [SW-1:0] LO  = SW'(PWM_IDLE);
    localparam logic signed [SW-1:0] HI  = SW'(PWM_MAX);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        SPINUP   = 2'd1,
        ACTIVE   = 2'd2,
        FAILSAFE = 2'd3
    } state_t;

    state_t state, state_nx;
    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [STW-1:0]    spin_cnt;
    logic [WW-1:0]     wdog, wdog_nx;
    logic [DUTY_W-1:0] cur_thr, thr_goal, thr_ramp, thr_down;
    logic              accept;

    logic                     s1_v, s2_v;
    logic signed [CORR_W-1:0] s1_p, s1_r, s1_y;
    logic [DUTY_W-1:0]        s1_t;
    logic signed [SW-1:0]     pe, re, ye, te;
    logic signed [SW-1:0]     mix [4];
    logic signed [SW-1:0]     s2_m [4];

    assign tick      = (tick_cnt == TW'(RAMP_DIV - 1));
    assign mix_state = state;
    assign accept    = corr_valid && arm && (state == ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    always_comb begin
        thr_goal = thr_target;
        if (thr_target < P_IDLE)     thr_goal = P_IDLE;
        else if (thr_target > P_MAX) thr_goal = P_MAX;

        thr_ramp = cur_thr;
        if (cur_thr < thr_goal)
            thr_ramp = (thr_goal - cur_thr > STEP) ? cur_thr + STEP : thr_goal;
        else if (cur_thr > thr_goal)
            thr_ramp = (cur_thr - thr_goal > STEP) ? cur_thr - STEP : thr_goal;

        thr_down = (cur_thr - P_IDLE > STEP) ? cur_thr - STEP : P_IDLE;

        // A frame in the timeout cycle clears the watchdog, so it wins over the timeout.
        if (corr_valid)                        wdog_nx = '0;
        else if (wdog == WW'(TIMEOUT_CYC))     wdog_nx = wdog;
        else                                   wdog_nx = wdog + 1'b1;
    end

    always_comb begin
        state_nx = state;
        if (!arm) begin
            state_nx = DISARMED;
        end else begin
            case (state)
                DISARMED: if (thr_target <= P_IDLE && !failsafe) state_nx = SPINUP;
                SPINUP:   if (tick && spin_cnt == STW'(SPIN_TICKS - 1)) state_nx = ACTIVE;
                ACTIVE:   if (wdog_nx == WW'(TIMEOUT_CYC)) state_nx = FAILSAFE;
                FAILSAFE: if (tick && cur_thr == P_IDLE) state_nx = DISARMED;
                default:  state_nx = DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DISARMED;
            spin_cnt <= '0;
            wdog     <= '0;
            cur_thr  <= P_IDLE;
            failsafe <= 1'b0;
        end else begin
            state    <= state_nx;
            spin_cnt <= (state == SPINUP) ? (tick ? spin_cnt + 1'b1 : spin_cnt) : '0;
            wdog     <= (state == ACTIVE) ? wdog_nx : '0;
            case (state)
                ACTIVE:   if (tick) cur_thr <= thr_ramp;
                FAILSAFE: if (tick) cur_thr <= thr_down;
                default:  cur_thr <= P_IDLE;
            endcase
            if (!arm)
                failsafe <= 1'b0;
            else if (state == ACTIVE && state_nx == FAILSAFE)
                failsafe <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= accept;
            s2_v <= s1_v && arm;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_p <= corr_pitch >>> CORR_SHIFT;
            s1_r <= corr_roll  >>> CORR_SHIFT;
            s1_y <= corr_yaw   >>> CORR_SHIFT;
            s1_t <= cur_thr;
        end
        for (int unsigned i = 0; i < 4; i++) s2_m[i] <= mix[i];
    end

    always_comb begin
        pe = SW'(s1_p);
        re = SW'(s1_r);
        ye = SW'(s1_y);
        te = SW'(s1_t);
        if (MIX_MODE == 0) begin
            mix[0] = te + pe + re - ye;
            mix[1] = te + pe - re + ye;
            mix[2] = te - pe - re - ye;
            mix[3] = te - pe + re + ye;
        end else begin
            mix[0] = te + pe - ye;
            mix[1] = te - re + ye;
            mix[2] = te - pe - ye;
            mix[3] = te + re + ye;
        end
    end

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic signed [SW-1:0] s);
        if (s < LO)      return P_IDLE;
        else if (s > HI) return P_MAX;
        else             return s[DUTY_W-1:0];
    endfunction

    // Disarm publish outranks everything; in-flight frames are dropped by the flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_1  <= P_MIN;
            duty_2  <= P_MIN;
            duty_3  <= P_MIN;
            duty_4  <= P_MIN;
            duty_oe <= 1'b0;
        end else begin
            duty_oe <= 1'b0;
            if (state != DISARMED && state_nx == DISARMED) begin
                {duty_1, duty_2, duty_3, duty_4} <= {4{P_MIN}};
                duty_oe <= 1'b1;
            end else if (state == SPINUP && tick) begin
                {duty_1, duty_2, duty_3, duty_4} <= {4{P_IDLE}};
                duty_oe <= 1'b1;
            end else if (state == FAILSAFE && tick) begin
                {duty_1, duty_2, duty_3, duty_4} <= {4{thr_down}};
                duty_oe <= 1'b1;
            end else if (s2_v && arm) begin
                duty_1  <= clamp_duty(s2_m[0]);
                duty_2  <= clamp_duty(s2_m[1]);
                duty_3  <= clamp_duty(s2_m[2]);
                duty_4  <= clamp_duty(s2_m[3]);
                duty_oe <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_motor_mix_ctrl.sv
// Randomised bench for motor_mix_ctrl: two instances (quad-X and quad-plus) checked
// every cycle against an arithmetic model, plus hand-computed anchor values.
module tb_motor_mix_ctrl;
    localparam int RDIV = 4;
    localparam int SPIN = 5;
    localparam int TMO  = 200;
    localparam int IDLE = 8000;
    localparam int PMAX = 60000;
    localparam int PMIN = 0;
    localparam int STEP = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic [15:0] thr_target;
    logic        corr_valid;
    logic [23:0] corr_pitch, corr_roll, corr_yaw;

    logic [15:0] x_d [4];
    logic [15:0] p_d [4];
    logic        x_oe, p_oe, x_fs, p_fs;
    logic [1:0]  x_state, p_state;

    always #5 clk = ~clk;

    motor_mix_ctrl #(.MIX_MODE(0), .RAMP_DIV(RDIV), .SPIN_TICKS(SPIN), .TIMEOUT_CYC(TMO)) dut_x (
        .clk(clk), .rst_n(rst_n), .arm(arm), .thr_target(thr_target),
        .corr_valid(corr_valid), .corr_pitch(corr_pitch), .corr_roll(corr_roll), .corr_yaw(corr_yaw),
        .duty_1(x_d[0]), .duty_2(x_d[1]), .duty_3(x_d[2]), .duty_4(x_d[3]),
        .duty_oe(x_oe), .mix_state(x_state), .failsafe(x_fs));

    motor_mix_ctrl #(.MIX_MODE(1), .RAMP_DIV(RDIV), .SPIN_TICKS(SPIN), .TIMEOUT_CYC(TMO)) dut_p (
        .clk(clk), .rst_n(rst_n), .arm(arm), .thr_target(thr_target),
        .corr_valid(corr_valid), .corr_pitch(corr_pitch), .corr_roll(corr_roll), .corr_yaw(corr_yaw),
        .duty_1(p_d[0]), .duty_2(p_d[1]), .duty_3(p_d[2]), .duty_4(p_d[3]),
        .duty_oe(p_oe), .mix_state(p_state), .failsafe(p_fs));

    typedef struct packed {
        int               due;
        logic [3:0][15:0] dx;
        logic [3:0][15:0] dp;
    } frame_t;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               m_state, m_thr, m_spin, m_silent, m_tcount, m_cyc;
    bit               m_fs;
    logic             e_oe;
    logic [3:0][15:0] e_dx, e_dp;
    frame_t           q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Motor k gets t + cp[k]*p + cr[k]*r + cy[k]*y, then clamps to the armed range.
    function automatic logic [3:0][15:0] mix_model(input int mode, input int t,
                                                   input int p, input int r, input int y);
        int cp[4], cr[4], cy[4];
        logic [3:0][15:0] res;
        if (mode == 0) begin
            cp = '{1, 1, -1, -1}; cr = '{1, -1, -1, 1}; cy = '{-1, 1, -1, 1};
        end else begin
            cp = '{1, 0, -1, 0};  cr = '{0, -1, 0, 1};  cy = '{-1, 1, -1, 1};
        end
        for (int k = 0; k < 4; k++)
            res[k] = 16'(clampi(t + cp[k]*p + cr[k]*r + cy[k]*y, IDLE, PMAX));
        return res;
    endfunction

    function automatic int scaled(input logic [23:0] c);
        return int'($signed(c)) >>> 8;
    endfunction

    task automatic publish_all(input int v);
        e_oe = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e_dx[k] = 16'(v);
            e_dp[k] = 16'(v);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_thr = IDLE; m_spin = 0; m_silent = 0; m_tcount = 0; m_cyc = 0;
        m_fs = 1'b0; e_oe = 1'b0; q.delete();
        for (int k = 0; k < 4; k++) begin
            e_dx[k] = 16'(PMIN);
            e_dp[k] = 16'(PMIN);
        end
    endtask

    task automatic model_step();
        bit     tk;
        int     goal;
        frame_t f;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tk = (m_tcount % RDIV) == RDIV - 1;
        m_tcount++;
        m_cyc++;
        e_oe = 1'b0;
        if (!arm) begin
            if (m_state != 0) publish_all(PMIN);
            m_state = 0; m_fs = 1'b0; m_thr = IDLE; q.delete();
        end else begin
            case (m_state)
                0: if (int'(thr_target) <= IDLE && !m_fs) begin m_state = 1; m_spin = 0; end
                1: if (tk) begin
                    publish_all(IDLE);
                    m_spin++;
                    if (m_spin == SPIN) begin m_state = 2; m_thr = IDLE; m_silent = 0; end
                end
                2: begin
                    if (corr_valid) begin
                        f.due = m_cyc + 2;
                        f.dx  = mix_model(0, m_thr, scaled(corr_pitch), scaled(corr_roll), scaled(corr_yaw));
                        f.dp  = mix_model(1, m_thr, scaled(corr_pitch), scaled(corr_roll), scaled(corr_yaw));
                        q.push_back(f);
                        m_silent = 0;
                    end else begin
                        m_silent++;
                        if (m_silent == TMO) begin m_state = 3; m_fs = 1'b1; end
                    end
                    if (tk) begin
                        goal  = clampi(int'(thr_target), IDLE, PMAX);
                        m_thr = (m_thr < goal) ? clampi(m_thr + STEP, m_thr, goal)
                                               : clampi(m_thr - STEP, goal, m_thr);
                    end
                end
                default: if (tk) begin
                    if (m_thr == IDLE) begin
                        m_state = 0;
                        publish_all(PMIN);
                    end else begin
                        m_thr = clampi(m_thr - STEP, IDLE, PMAX);
                        publish_all(m_thr);
                    end
                end
            endcase
            if (q.size() > 0 && q[0].due == m_cyc) begin
                f = q.pop_front();
                e_oe = 1'b1; e_dx = f.dx; e_dp = f.dp;
            end
        end
    endtask

    task automatic compare_all();
        chk("x_state", int'(x_state), m_state);
        chk("p_state", int'(p_state), m_state);
        chk("x_failsafe", int'(x_fs), int'(m_fs));
        chk("p_failsafe", int'(p_fs), int'(m_fs));
        chk("x_oe", int'(x_oe), int'(e_oe));
        chk("p_oe", int'(p_oe), int'(e_oe));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("x_duty%0d", k + 1), int'(x_d[k]), int'(e_dx[k]));
            chk($sformatf("p_duty%0d", k + 1), int'(p_d[k]), int'(e_dp[k]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #2;
        compare_all();
    endtask

    task automatic reach_active(input string name);
        for (int i = 0; i < 200 && x_state != 2'd2; i++) cycle();
        chk(name, int'(x_state), 2);
    endtask

    task automatic ramp_with_frames(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            corr_valid = (i % 20 == 0);
            corr_pitch = 24'($urandom); corr_roll = 24'($urandom); corr_yaw = 24'($urandom);
            cycle();
        end
        corr_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int cnt, n, r;
        rst_n = 1'b0; arm = 1'b0; thr_target = '0; corr_valid = 1'b0;
        corr_pitch = '0; corr_roll = '0; corr_yaw = '0;
        model_reset();
        repeat (3) cycle();
        chk("rst_state", int'(x_state), 0);
        chk("rst_duty1", int'(x_d[0]), 0);
        chk("rst_oe", int'(x_oe), 0);
        rst_n = 1'b1;

        // High-throttle arming is locked out.
        arm = 1'b1; thr_target = 16'd30000;
        repeat (40) cycle();
        chk("lockout_state", int'(x_state), 0);
        chk("lockout_duty", int'(x_d[0]), 0);

        thr_target = '0;
        cycle();
        chk("arm_spinup", int'(x_state), 1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (x_oe) begin
                cnt++;
                chk("spin_duty", int'(x_d[2]), IDLE);
            end
            if (x_state == 2'd2) break;
        end
        chk("spin_pulses", cnt, SPIN);
        chk("spin_active", int'(x_state), 2);

        // Ramp to 30000, then anchor the mix and latency with literal values.
        thr_target = 16'd30000;
        ramp_with_frames(480);
        corr_valid = 1'b1; corr_pitch = '0; corr_roll = '0; corr_yaw = '0;
        cycle();
        corr_valid = 1'b0;
        cycle(); cycle();
        chk("thr_reached", int'(x_d[0]), 30000);
        corr_valid = 1'b1; corr_pitch = 24'd2560;
        cycle();
        corr_valid = 1'b0; corr_pitch = '0;
        cycle();
        chk("lat_oe_early", int'(x_oe), 0);
        cycle();
        chk("lat_oe", int'(x_oe), 1);
        chk("xmix_d1", int'(x_d[0]), 30010);
        chk("xmix_d2", int'(x_d[1]), 30010);
        chk("xmix_d3", int'(x_d[2]), 29990);
        chk("xmix_d4", int'(x_d[3]), 29990);
        corr_valid = 1'b1; corr_roll = 24'h7FFFFF;
        cycle();
        corr_valid = 1'b0; corr_roll = '0;
        cycle(); cycle();
        chk("plus_d1", int'(p_d[0]), 30000);
        chk("plus_d2", int'(p_d[1]), 8000);
        chk("plus_d3", int'(p_d[2]), 30000);
        chk("plus_d4", int'(p_d[3]), 60000);

        // Random traffic, throttle changes and occasional disarms.
        for (int i = 0; i < 2000; i++) begin
            corr_valid = ($urandom_range(99) < 30);
            corr_pitch = 24'($urandom); corr_roll = 24'($urandom); corr_yaw = 24'($urandom);
            if ($urandom_range(99) < 5) begin
                r = $urandom_range(3);
                thr_target = (r == 0) ? 16'd0 : (r == 1) ? 16'($urandom_range(IDLE)) :
                             (r == 2) ? 16'd30000 : 16'($urandom);
            end
            if (arm) arm = ($urandom_range(199) != 0);
            else     arm = ($urandom_range(1) == 1);
            cycle();
        end

        // Failsafe: silence at 30000, descent, re-arm blocked until arm drops.
        corr_valid = 1'b0; arm = 1'b0; thr_target = '0;
        cycle();
        arm = 1'b1;
        reach_active("fs_rearm");
        thr_target = 16'd30000;
        ramp_with_frames(480);
        corr_valid = 1'b1;
        cycle();
        corr_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            cycle();
            if (x_state == 2'd3) begin n = i; break; end
        end
        chk("fs_latency", n, TMO);
        chk("fs_flag", int'(x_fs), 1);
        cnt = 0;
        for (int i = 0; i < 700; i++) begin
            cycle();
            if (x_oe) cnt++;
            if (x_state == 2'd0) break;
        end
        chk("fs_pulses", cnt, 111);
        chk("fs_final_duty", int'(x_d[3]), 0);
        chk("fs_disarmed", int'(x_state), 0);
        chk("fs_sticky", int'(x_fs), 1);
        thr_target = '0;
        repeat (20) cycle();
        chk("fs_rearm_blocked", int'(x_state), 0);
        arm = 1'b0;
        cycle();
        chk("fs_cleared", int'(x_fs), 0);
        arm = 1'b1;
        cycle();
        chk("fs_rearm_ok", int'(x_state), 1);

        // Disarm with a frame in flight: only the PWM_MIN publish appears.
        reach_active("dm_active");
        corr_valid = 1'b1; corr_pitch = 24'd2560;
        cycle();
        corr_valid = 1'b0; arm = 1'b0;
        cycle();
        cnt = int'(x_oe);
        chk("dm_duty", int'(x_d[0]), 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            cnt += int'(x_oe);
        end
        chk("dm_oe_count", cnt, 1);
        chk("dm_state", int'(x_state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
